// File: rtl/uart_pkg.sv
// UART line definitions shared by the TX and RX blocks.
// State encoding, line levels and baud divisor helper.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   function automatic int clks_per_bit(input int clk_freq,
                                       input int bit_rate);
      return clk_freq / bit_rate;
   endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and ticks on the
// last count; clear restarts the period.
module baud_counter #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO reader that serialises each popped word as an
// 8N1-style UART frame; frames run back-to-back.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BIT_RATE  = 115_200,
   parameter int WIDTH     = 8,
   parameter int STOP_BITS = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_read_data,
   output logic             fifo_read,
   output logic             tx,
   output logic             busy
);

   localparam int CPB = clks_per_bit(CLK_FREQ, BIT_RATE);
   localparam int BW  = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   uart_state_e      state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             tx_q, tx_d;
   logic             tick, clear;

   baud_counter #(
      .CLKS_PER_BIT(CPB)
   ) u_baud (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (clear),
      .tick   (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      fifo_read = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tx_d = LINE_IDLE;
            // reset_n gate keeps the pop strobe quiet while held in reset
            if (!fifo_empty && reset_n) begin
               fifo_read = 1'b1;
               shift_d   = fifo_read_data;
               bit_d     = '0;
               tx_d      = LINE_START;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_q == LAST_BIT) begin
                  bit_d   = '0;
                  tx_d    = LINE_STOP;
                  state_d = ST_STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_d[0];
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == LAST_STOP) begin
                  bit_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign clear = (state_q == ST_IDLE) || (state_d != state_q);
   assign tx    = tx_q;
   assign busy  = (state_q != ST_IDLE) || fifo_read;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a 1-stop and a 2-stop instance run against
// a queue-based line model and a sampling UART receiver.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] emp = 2'b11;
   logic [1:0] rd, tx, busy;
   logic [7:0] dat [2];

   logic [7:0] fq [2][$];
   bit         lq [2][$];
   int         pop_t [2][$];
   logic [7:0] sent [$];
   logic [7:0] rxq [$];

   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   int busy_n, pop_n, n0;
   bit rx_on = 1'b0;
   int rx_t = 0;
   logic [7:0] rx_b;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLK_FREQ (1_000_000),
      .BIT_RATE (250_000),
      .WIDTH    (8),
      .STOP_BITS(1)
   ) dut_a (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_empty    (emp[0]),
      .fifo_read_data(dat[0]),
      .fifo_read     (rd[0]),
      .tx            (tx[0]),
      .busy          (busy[0])
   );

   fifo_uart_tx #(
      .CLK_FREQ (1_000_000),
      .BIT_RATE (250_000),
      .WIDTH    (8),
      .STOP_BITS(2)
   ) dut_b (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_empty    (emp[1]),
      .fifo_read_data(dat[1]),
      .fifo_read     (rd[1]),
      .tx            (tx[1]),
      .busy          (busy[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t",
                tag, obs, exp, $time);
      end
   endtask

   // one clock of model + DUT; entered and left at posedge+1
   task automatic cycle(input bit noisy);
      bit idle [2];
      bit ep [2];
      logic [7:0] b;
      int k;
      for (int d = 0; d < 2; d++) begin
         idle[d] = (lq[d].size() == 0);
         if (idle[d] || !noisy) begin
            emp[d] = (fq[d].size() == 0);
            dat[d] = emp[d] ? 8'($urandom) : fq[d][0];
         end else begin
            emp[d] = 1'($urandom);
            dat[d] = 8'($urandom);
         end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         ep[d] = idle[d] && !emp[d];
         chk($sformatf("tx%0d@%0d", d, cyc), 32'(tx[d]),
             32'(idle[d] ? 1'b1 : lq[d][0]));
         chk($sformatf("rd%0d@%0d", d, cyc), 32'(rd[d]), 32'(ep[d]));
         chk($sformatf("busy%0d@%0d", d, cyc), 32'(busy[d]),
             32'(!idle[d] || ep[d]));
      end
      if (busy[0] === 1'b1) busy_n++;
      if (rd[0] === 1'b1) pop_n++;
      if (rx_on) rx_t++;
      else if (tx[0] === 1'b0) begin
         rx_on = 1'b1;
         rx_t  = 0;
      end
      if (rx_on && rx_t > CPB && (rx_t % CPB) == CPB / 2) begin
         k = rx_t / CPB - 1;
         if (k < 8) rx_b[k] = tx[0];
         else begin
            rx_on = 1'b0;
            if (tx[0] === 1'b1) rxq.push_back(rx_b);
         end
      end
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (!idle[d]) void'(lq[d].pop_front());
         else if (ep[d]) begin
            b = fq[d].pop_front();
            pop_t[d].push_back(cyc);
            if (d == 0) sent.push_back(b);
            for (int j = 0; j < CPB; j++) lq[d].push_back(1'b0);
            for (int i = 0; i < 8; i++)
               for (int j = 0; j < CPB; j++) lq[d].push_back(b[i]);
            for (int j = 0; j < CPB * (d + 1); j++) lq[d].push_back(1'b1);
         end
      end
      #1;
   endtask

   initial begin
      emp = 2'b00;
      dat[0] = 8'h5A;
      dat[1] = 8'hC3;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_tx", 32'(tx[d]), 32'd1);
         chk("rst_rd", 32'(rd[d]), 32'd0);
         chk("rst_busy", 32'(busy[d]), 32'd0);
      end
      emp = 2'b11;
      reset_n = 1'b1;

      repeat (100) cycle(1'b0);

      fq[0].push_back(8'hA5);
      busy_n = 0;
      pop_n = 0;
      repeat (50) cycle(1'b0);
      chk("a5_busy_cycles", 32'(busy_n), 32'd41);
      chk("a5_pops", 32'(pop_n), 32'd1);

      pop_t[0].delete();
      fq[0].push_back(8'h00);
      fq[0].push_back(8'hFF);
      fq[0].push_back(8'h55);
      repeat (130) cycle(1'b0);
      chk("b2b_pops", 32'(pop_t[0].size()), 32'd3);
      if (pop_t[0].size() == 3) begin
         chk("b2b_gap1", 32'(pop_t[0][1] - pop_t[0][0]), 32'd41);
         chk("b2b_gap2", 32'(pop_t[0][2] - pop_t[0][1]), 32'd41);
      end

      for (int d = 0; d < 2; d++) begin
         fq[d].push_back(8'($urandom));
         fq[d].push_back(8'($urandom));
      end
      repeat (120) cycle(1'b1);

      pop_t[0].delete();
      fq[0].push_back(8'h3C);
      fq[0].push_back(8'h96);
      for (int i = 0; i < 10 && pop_t[0].size() == 0; i++) cycle(1'b0);
      chk("rst_frame_started", 32'(pop_t[0].size()), 32'd1);
      repeat (17) cycle(1'b0);
      reset_n = 1'b0;
      #1;
      chk("midrst_tx", 32'(tx[0]), 32'd1);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_rd", 32'(rd[0]), 32'd0);
      if (lq[0].size() != 0) void'(sent.pop_back());
      lq[0].delete();
      lq[1].delete();
      rx_on = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pop_t[0].delete();
      repeat (50) cycle(1'b0);
      chk("after_rst_pops", 32'(pop_t[0].size()), 32'd1);
      chk("after_rst_fifo", 32'(fq[0].size()), 32'd0);

      pop_t[1].delete();
      fq[1].push_back(8'h81);
      fq[1].push_back(8'($urandom));
      repeat (100) cycle(1'b0);
      chk("stop2_pops", 32'(pop_t[1].size()), 32'd2);
      if (pop_t[1].size() == 2)
         chk("stop2_gap", 32'(pop_t[1][1] - pop_t[1][0]), 32'd45);

      for (int it = 0; it < 20; it++) begin
         for (int d = 0; d < 2; d++)
            if ($urandom_range(0, 3) != 0) fq[d].push_back(8'($urandom));
         repeat ($urandom_range(30, 60)) cycle(1'($urandom));
      end
      repeat (300) cycle(1'b0);

      chk("rx_count", 32'(rxq.size()), 32'(sent.size()));
      for (int i = 0; i < rxq.size() && i < sent.size(); i++)
         chk($sformatf("rx_byte%0d", i), 32'(rxq[i]), 32'(sent[i]));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
